vec_sum_accum: RTL

VEC_SUM_ACCUM -- requirements
Module: vec_sum_accum

---
 rtl/vec_sum_if.sv | 28 ++
 rtl/vec_sum_accum.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/vec_sum_if.sv
// Handshake bundle for vec_sum_accum: input beat channel and frame result channel.
// Valid/ready rule on both channels: a transfer occurs on a rising edge where valid && ready.
interface vec_sum_if #(
  parameter int N_ELEM = 8,
  parameter int ELEM_W = 16,
  parameter int SUM_W  = 32,
  parameter int CNT_W  = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic [N_ELEM*ELEM_W-1:0] in_data;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [SUM_W-1:0]         out_sum;
  logic [CNT_W-1:0]         out_count;
  logic                     out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/vec_sum_accum.sv
// Saturating per-frame accumulator of N_ELEM-element beat sums with a one-slot result register.
// Macro VEC_SUM_SQUARE_EN: terms are squared elements, registered in one extra stage (latency 2).
module vec_sum_accum #(
  parameter int N_ELEM = 8,
  parameter int ELEM_W = 16,
  parameter int SUM_W  = 32,
  parameter int CNT_W  = 16
) (
  input  logic     clk,
  input  logic     rst,
  vec_sum_if.slave bus
);

`ifdef VEC_SUM_SQUARE_EN
  localparam int TERM_W = 2 * ELEM_W;
`else
  localparam int TERM_W = ELEM_W;
`endif
  localparam int BS_W  = TERM_W + $clog2(N_ELEM);
  localparam int EXT_W = ((BS_W > SUM_W) ? BS_W : SUM_W) + 1;
  localparam logic [SUM_W-1:0] SUM_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              out_valid_q, out_valid_d;
  logic [SUM_W-1:0]  out_sum_q, out_sum_d;
  logic [CNT_W-1:0]  out_count_q, out_count_d;
  logic              out_ovf_q, out_ovf_d;
  logic [SUM_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  logic              in_fire;
  logic [TERM_W-1:0] term_in [N_ELEM];
  logic              b_valid;
  logic              b_last;
  logic [TERM_W-1:0] b_term [N_ELEM];
  logic [BS_W-1:0]   beat_sum;
  logic [EXT_W-1:0]  total;
  logic              sat;
  logic [SUM_W-1:0]  sum_sat;
  logic [CNT_W-1:0]  cnt_inc;

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign in_fire       = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_count = out_count_q;
  assign bus.out_ovf   = out_ovf_q;

  always_comb begin
    for (int i = 0; i < N_ELEM; i++) begin
`ifdef VEC_SUM_SQUARE_EN
      term_in[i] = TERM_W'(bus.in_data[i*ELEM_W +: ELEM_W]) * TERM_W'(bus.in_data[i*ELEM_W +: ELEM_W]);
`else
      term_in[i] = bus.in_data[i*ELEM_W +: ELEM_W];
`endif
    end
  end

`ifdef VEC_SUM_SQUARE_EN
  logic              s1_valid_q, s1_valid_d;
  logic              s1_last_q, s1_last_d;
  logic [TERM_W-1:0] s1_term_q [N_ELEM];
  logic [TERM_W-1:0] s1_term_d [N_ELEM];
  logic              s1_adv;

  // A staged last beat waits while the result slot is full; in_ready is low then too,
  // so the stage never has to absorb a second beat while stalled.
  assign s1_adv  = s1_valid_q && (!s1_last_q || !out_valid_q || bus.out_ready);
  assign b_valid = s1_adv;
  assign b_last  = s1_last_q;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_last_d  = s1_last_q;
    for (int i = 0; i < N_ELEM; i++) begin
      s1_term_d[i] = s1_term_q[i];
      b_term[i]    = s1_term_q[i];
    end
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_last_d  = bus.in_last;
      for (int i = 0; i < N_ELEM; i++) s1_term_d[i] = term_in[i];
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      for (int i = 0; i < N_ELEM; i++) s1_term_q[i] <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      for (int i = 0; i < N_ELEM; i++) s1_term_q[i] <= s1_term_d[i];
    end
  end
`else
  assign b_valid = in_fire;
  assign b_last  = bus.in_last;

  always_comb begin
    for (int i = 0; i < N_ELEM; i++) b_term[i] = term_in[i];
  end
`endif

  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < N_ELEM; i++) beat_sum = beat_sum + BS_W'(b_term[i]);
  end

  // Extra headroom bit lets the compare detect any overshoot past SUM_MAX.
  assign total   = EXT_W'(acc_q) + EXT_W'(beat_sum);
  assign sat     = total > EXT_W'(SUM_MAX);
  assign sum_sat = sat ? SUM_MAX : total[SUM_W-1:0];
  assign cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);

  always_comb begin
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
    if (b_valid) begin
      if (b_last) begin
        out_valid_d = 1'b1;
        out_sum_d   = sum_sat;
        out_count_d = cnt_inc;
        out_ovf_d   = ovf_q || sat;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
      end else begin
        acc_d = sum_sat;
        cnt_d = cnt_inc;
        ovf_d = ovf_q || sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule
